// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, absolute/relative jump, call/return.
// Define PC_SEQ_CALLSTACK_EN to build in the return-address stack.
module pc_seq #(
    parameter int D = 12,
    parameter int STACK_DEPTH = 4,
    parameter logic [D-1:0] RESET_VEC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         absjump_en,
    input  logic [D-1:0] target,
    input  logic         reljump_en,
    input  logic [D-1:0] offset,
    input  logic         call_en,
    input  logic         ret_en,
    output logic [D-1:0] prog_ctr,
    output logic         stack_empty,
    output logic         stack_full,
    output logic         stack_err
);

    logic [D-1:0] pc_next;
    logic [D-1:0] pc_inc;

    assign pc_inc = prog_ctr + D'(1);

`ifdef PC_SEQ_CALLSTACK_EN
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [D-1:0]  stack [STACK_DEPTH];
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          err_set;

    assign stack_empty = (count == '0);
    assign stack_full  = (count == CW'(STACK_DEPTH));

    always_comb begin
        pc_next = prog_ctr;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (!stall) begin
            if (ret_en) begin
                if (!stack_empty) begin
                    pc_next = stack[0];
                    pop     = 1'b1;
                end else begin
                    pc_next = pc_inc;
                    err_set = 1'b1;
                end
            end else if (call_en) begin
                pc_next = target;
                push    = 1'b1;
                err_set = stack_full;
            end else if (absjump_en) begin
                pc_next = target;
            end else if (reljump_en) begin
                pc_next = prog_ctr + offset;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr  <= RESET_VEC;
            count     <= '0;
            stack_err <= 1'b0;
        end else begin
            prog_ctr <= pc_next;
            if (err_set)
                stack_err <= 1'b1;
            if (push && !stack_full)
                count <= count + CW'(1);
            else if (pop)
                count <= count - CW'(1);
        end
    end

    // Entry 0 is the top; a push onto a full stack shifts the oldest entry out.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[0] <= pc_inc;
            for (int i = 1; i < STACK_DEPTH; i++)
                stack[i] <= stack[i-1];
        end else if (pop) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++)
                stack[i] <= stack[i+1];
        end
    end
`else
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;

    // Without a stack, a return is a plain increment and a call a plain jump.
    always_comb begin
        pc_next = prog_ctr;
        if (!stall) begin
            if (ret_en)
                pc_next = pc_inc;
            else if (call_en || absjump_en)
                pc_next = target;
            else if (reljump_en)
                pc_next = prog_ctr + offset;
            else
                pc_next = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prog_ctr <= RESET_VEC;
        else
            prog_ctr <= pc_next;
    end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq (D=12, STACK_DEPTH=4, RESET_VEC=0).
module tb_pc_seq;
    logic        clk;
    logic        reset;
    logic        stall;
    logic        absjump_en;
    logic [11:0] target;
    logic        reljump_en;
    logic [11:0] offset;
    logic        call_en;
    logic        ret_en;
    logic [11:0] prog_ctr;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_err;

    int vectorCount = 0;
    int missCount = 0;

    pc_seq #(.D(12), .STACK_DEPTH(4), .RESET_VEC(12'h000)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .absjump_en(absjump_en),
        .target(target),
        .reljump_en(reljump_en),
        .offset(offset),
        .call_en(call_en),
        .ret_en(ret_en),
        .prog_ctr(prog_ctr),
        .stack_empty(stack_empty),
        .stack_full(stack_full),
        .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls, take the edge, then release the controls.
    task automatic applyStimulus(input logic st, input logic ab, input logic [11:0] tg,
                                 input logic rj, input logic [11:0] off,
                                 input logic ca, input logic re);
        stall = st; absjump_en = ab; target = tg;
        reljump_en = rj; offset = off; call_en = ca; ret_en = re;
        @(posedge clk);
        #1;
        stall = 0; absjump_en = 0; target = '0;
        reljump_en = 0; offset = '0; call_en = 0; ret_en = 0;
    endtask

    initial begin
        reset = 0; stall = 0; absjump_en = 0; target = '0;
        reljump_en = 0; offset = '0; call_en = 0; ret_en = 0;
        #3;
        checkOutput("rst_pc", prog_ctr, 12'h000);
        checkOutput("rst_empty", stack_empty, 1);
        checkOutput("rst_full", stack_full, 0);
        checkOutput("rst_err", stack_err, 0);
        #5 reset = 1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("inc1", prog_ctr, 12'h001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("inc2", prog_ctr, 12'h002);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("inc3", prog_ctr, 12'h003);

        applyStimulus(0, 1, 12'hFFE, 0, 0, 0, 0); checkOutput("abs_ffe", prog_ctr, 12'hFFE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);       checkOutput("inc_fff", prog_ctr, 12'hFFF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);       checkOutput("wrap", prog_ctr, 12'h000);

        applyStimulus(0, 1, 12'h010, 0, 0, 0, 0);    checkOutput("abs_010", prog_ctr, 12'h010);
        applyStimulus(0, 0, 0, 1, 12'hFFC, 0, 0);    checkOutput("rel_neg", prog_ctr, 12'h00C);
        applyStimulus(0, 0, 0, 1, 12'h005, 0, 0);    checkOutput("rel_pos", prog_ctr, 12'h011);
        applyStimulus(0, 1, 12'h300, 1, 12'h005, 0, 0); checkOutput("abs_over_rel", prog_ctr, 12'h300);
        applyStimulus(1, 1, 12'h123, 0, 0, 1, 1);    checkOutput("stall_hold", prog_ctr, 12'h300);

`ifdef PC_SEQ_CALLSTACK_EN
        applyStimulus(0, 1, 12'h020, 0, 0, 0, 0); checkOutput("abs_020", prog_ctr, 12'h020);
        applyStimulus(0, 0, 12'h100, 0, 0, 1, 0); checkOutput("call1", prog_ctr, 12'h100);
        checkOutput("call1_empty", stack_empty, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);       checkOutput("inc_101", prog_ctr, 12'h101);
        applyStimulus(0, 0, 12'h200, 0, 0, 1, 0); checkOutput("call2", prog_ctr, 12'h200);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);       checkOutput("ret1", prog_ctr, 12'h102);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);       checkOutput("ret2", prog_ctr, 12'h021);
        checkOutput("ret2_empty", stack_empty, 1);
        checkOutput("ret2_err", stack_err, 0);

        // Priority: stall freezes everything, then ret beats call and absjump.
        applyStimulus(0, 0, 12'h050, 0, 0, 1, 0); checkOutput("call_050", prog_ctr, 12'h050);
        applyStimulus(1, 1, 12'h300, 0, 0, 1, 1); checkOutput("stall_pc", prog_ctr, 12'h050);
        checkOutput("stall_empty", stack_empty, 0);
        applyStimulus(0, 1, 12'h300, 0, 0, 1, 1); checkOutput("ret_wins", prog_ctr, 12'h022);
        checkOutput("ret_wins_empty", stack_empty, 1);
        checkOutput("ret_wins_err", stack_err, 0);

        applyStimulus(0, 1, 12'h000, 0, 0, 0, 0); checkOutput("abs_000", prog_ctr, 12'h000);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 12'(i * 16), 0, 0, 1, 0);
            checkOutput("ovf_call", prog_ctr, 32'(i * 16));
        end
        checkOutput("four_full", stack_full, 1);
        checkOutput("four_err", stack_err, 0);
        applyStimulus(0, 0, 12'h050, 0, 0, 1, 0); checkOutput("call5", prog_ctr, 12'h050);
        checkOutput("call5_full", stack_full, 1);
        checkOutput("call5_err", stack_err, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("oret1", prog_ctr, 12'h041);
        checkOutput("oret1_full", stack_full, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("oret2", prog_ctr, 12'h031);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("oret3", prog_ctr, 12'h021);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("oret4", prog_ctr, 12'h011);
        checkOutput("oret4_empty", stack_empty, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("uflow_inc", prog_ctr, 12'h012);
        checkOutput("uflow_err", stack_err, 1);
        checkOutput("uflow_empty", stack_empty, 1);

        applyStimulus(0, 0, 12'h100, 0, 0, 1, 0); checkOutput("pre_rst_call1", prog_ctr, 12'h100);
        applyStimulus(0, 0, 12'h200, 0, 0, 1, 0); checkOutput("pre_rst_call2", prog_ctr, 12'h200);
        #3 reset = 0;
        #1;
        checkOutput("mid_rst_pc", prog_ctr, 12'h000);
        checkOutput("mid_rst_empty", stack_empty, 1);
        checkOutput("mid_rst_full", stack_full, 0);
        checkOutput("mid_rst_err", stack_err, 0);
        #1 reset = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("post_rst_inc", prog_ctr, 12'h001);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("post_rst_ret", prog_ctr, 12'h002);
        checkOutput("post_rst_err", stack_err, 1);
`else
        applyStimulus(0, 0, 12'h300, 0, 0, 1, 0); checkOutput("nostk_call", prog_ctr, 12'h300);
        checkOutput("nostk_empty", stack_empty, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);       checkOutput("nostk_ret", prog_ctr, 12'h301);
        checkOutput("nostk_err", stack_err, 0);
        checkOutput("nostk_full", stack_full, 0);
        applyStimulus(0, 1, 12'h400, 0, 0, 1, 1); checkOutput("nostk_ret_wins", prog_ctr, 12'h302);
        applyStimulus(0, 0, 12'h400, 1, 12'h010, 1, 0); checkOutput("nostk_call_over_rel", prog_ctr, 12'h400);
        #3 reset = 0;
        #1;
        checkOutput("nostk_mid_rst_pc", prog_ctr, 12'h000);
        #1 reset = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("nostk_post_rst", prog_ctr, 12'h001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter D, default 12: program-counter width in bits.
REQ-002 Parameter STACK_DEPTH, default 4: return-address stack entries; 2..16.
REQ-003 Parameter RESET_VEC, default 0: D-bit value loaded into prog_ctr on reset.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hold all state this cycle.
REQ-007 absjump_en  input  1  absolute jump to target.
REQ-008 target  input  D  absolute jump/call destination.
REQ-009 reljump_en  input  1  relative branch by offset.
REQ-010 offset  input  D  two's-complement branch displacement.
REQ-011 call_en  input  1  push return address, jump to target.
REQ-012 ret_en  input  1  pop return address into prog_ctr.
REQ-013 prog_ctr  output  D  current program counter (registered).
REQ-014 stack_empty  output  1  stack holds zero entries.
REQ-015 stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-016 stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-017 Per-cycle priority SHALL be: stall > ret_en > call_en > absjump_en > reljump_en > increment; lower-priority requests that cycle are ignored.
REQ-018 stall=1: prog_ctr, stack contents, pointer and stack_err SHALL hold.
REQ-019 Increment: prog_ctr <= prog_ctr + 1, modulo 2^D (all-ones wraps to 0).
REQ-020 absjump_en: prog_ctr <= target, one-cycle latency.
REQ-021 reljump_en: prog_ctr <= prog_ctr + offset, sign-extended, modulo 2^D.
REQ-022 call_en: push prog_ctr + 1 (modulo 2^D); prog_ctr <= target; same edge.
REQ-023 ret_en with stack non-empty: prog_ctr <= top entry; entry count decrements by 1.
REQ-024 call_en when stack_full: jump still taken; oldest entry discarded, new entry becomes top; count stays STACK_DEPTH; stack_err <= 1.
REQ-025 ret_en when stack_empty: treated as increment; count stays 0; stack_err <= 1.
REQ-026 stack_empty, stack_full SHALL be combinational decodes of the registered entry count.
REQ-027 stack_err SHALL clear only on reset.

Reset
REQ-028 reset=0 SHALL immediately, without clk, force prog_ctr=RESET_VEC, count=0, stack_err=0.
REQ-029 During reset: stack_empty=1, stack_full=0; stack entry storage need not clear.
REQ-030 Reset asserted mid-call/ret SHALL abandon the operation; first post-reset edge behaves per REQ-017 from RESET_VEC.
REQ-031 Reset deassertion is synchronous to clk at system level; no internal synchroniser.

Configuration
REQ-032 Macro PC_SEQ_CALLSTACK_EN SHALL compile in the return-address stack.
REQ-033 Defined: REQ-022..REQ-027 apply as written.
REQ-034 Undefined: no stack storage; call_en behaves exactly as absjump_en; ret_en behaves as increment; stack_empty=1, stack_full=0, stack_err=0 constant.

Verification
REQ-035 Reset low, then 3 clean clocks, D=12 -> prog_ctr 0,1,2,3; at 0xFFF next 0x000.
REQ-036 prog_ctr=0x010, reljump_en, offset=0xFFC -> 0x00C; offset=0x005 -> 0x011.
REQ-037 At 0x020 call target=0x100; at 0x101 call target=0x200; ret, ret -> 0x102 then 0x021; stack_empty=1, stack_err=0.
REQ-038 STACK_DEPTH=4: five calls from 0x000,0x010,0x020,0x030,0x040 -> stack_full=1, stack_err=1; five rets yield 0x041,0x031,0x021,0x011 then increment.
REQ-039 stall=1 with ret_en, call_en, absjump_en asserted -> prog_ctr, count unchanged; stall=0, all three asserted -> ret wins.
REQ-040 Reset pulsed between clocks with two entries pushed -> prog_ctr=RESET_VEC, stack_empty=1 before next edge; rebuild without PC_SEQ_CALLSTACK_EN, call target=0x300 -> prog_ctr 0x300, ret -> 0x301.
